hci_core_req_buffer: RTL and testbench

HCI_CORE_REQ_BUFFER -- requirements
Module: hci_core_req_buffer

---
 rtl/hci_core_req_buffer.sv | 146 ++++++++++++++
 tb/tb_hci_core_req_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hci_core_req_buffer.sv
// Request buffer between the load/store mixer and the memory interconnect.
// Requests are queued in a FIFO with no fall-through path and issued strictly
// in order. Loads are throttled once MAX_OUT of them are awaiting a response.
// Responses pass straight back upstream without storage.
module hci_core_req_buffer #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int BW      = 8,
  parameter int WW      = 32,
  parameter int OW      = 1,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  // upstream request side
  input  logic                    in_req_i,
  input  logic                    in_wen_i,
  input  logic                    in_lrdy_i,
  input  logic [AW-1:0]           in_add_i,
  input  logic [DW-1:0]           in_data_i,
  input  logic [DW/BW-1:0]        in_be_i,
  input  logic [DW/WW*OW-1:0]     in_boffs_i,
  output logic                    in_gnt_o,
  output logic                    in_r_valid_o,
  output logic                    in_r_opc_o,
  output logic [DW-1:0]           in_r_data_o,
  // downstream request side
  output logic                    out_req_o,
  output logic                    out_wen_o,
  output logic                    out_lrdy_o,
  output logic [AW-1:0]           out_add_o,
  output logic [DW-1:0]           out_data_o,
  output logic [DW/BW-1:0]        out_be_o,
  output logic [DW/WW*OW-1:0]     out_boffs_o,
  input  logic                    out_gnt_i,
  input  logic                    out_r_valid_i,
  input  logic                    out_r_opc_i,
  input  logic [DW-1:0]           out_r_data_i,
  // status
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                    resp_err_o
);

  localparam int BEW = DW / BW;
  localparam int BOW = DW / WW * OW;
  localparam int EW  = AW + 1 + BEW + DW + BOW;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);
  // Bit position of the wen flag inside a packed {add, wen, be, data, boffs} entry
  localparam int WEN_BIT = BOW + DW + BEW;

  logic [EW-1:0]  fifo_mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic [OCW-1:0] outst_reg;
  logic           err_reg;

  logic [EW-1:0]  head_entry;
  logic           head_wen;
  logic           full;
  logic           empty;
  logic           throttled;
  logic           push;
  logic           pop;
  logic           load_pop;

  // Pointer advance with explicit wrap so non power-of-two depths work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_wen   = head_entry[WEN_BIT];
  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign throttled  = head_wen && (outst_reg == OCW'(MAX_OUT));

  // Grant depends only on occupancy; a same-cycle pop never frees a full FIFO
  assign in_gnt_o   = !full;
  assign out_req_o  = !empty && !throttled;
  assign push       = in_req_i && in_gnt_o && !clear_i;
  assign pop        = out_req_o && out_gnt_i && !clear_i;
  assign load_pop   = pop && head_wen;

  assign {out_add_o, out_wen_o, out_be_o, out_data_o, out_boffs_o} = head_entry;
  assign occupancy_o = count_reg;
  assign resp_err_o  = err_reg;

  // Responses and the lrdy hint bypass the buffer entirely
  assign in_r_valid_o = out_r_valid_i;
  assign in_r_opc_o   = out_r_opc_i;
  assign in_r_data_o  = out_r_data_i;
  assign out_lrdy_o   = in_lrdy_i;

  // Entry storage; contents are only meaningful between rd and wr pointers
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_add_i, in_wen_i, in_be_i, in_data_i, in_boffs_i};
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Outstanding-load counter and sticky flag for responses nobody asked for
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_reg <= '0;
      err_reg   <= 1'b0;
    end else if (clear_i) begin
      outst_reg <= '0;
      err_reg   <= 1'b0;
    end else if (load_pop && !out_r_valid_i) begin
      outst_reg <= outst_reg + 1'b1;
    end else if (!load_pop && out_r_valid_i) begin
      if (outst_reg == '0) begin
        err_reg <= 1'b1;
      end else begin
        outst_reg <= outst_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hci_core_req_buffer.sv
// Directed bench for hci_core_req_buffer at default parameters
// (DEPTH=4, MAX_OUT=2): vector table plus hand sequences for wrap and reset.
module tb_hci_core_req_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        in_req_i, in_wen_i, in_lrdy_i;
  logic [31:0] in_add_i, in_data_i;
  logic [3:0]  in_be_i;
  logic [0:0]  in_boffs_i;
  logic        in_gnt_o, in_r_valid_o, in_r_opc_o;
  logic [31:0] in_r_data_o;
  logic        out_req_o, out_wen_o, out_lrdy_o;
  logic [31:0] out_add_o, out_data_o;
  logic [3:0]  out_be_o;
  logic [0:0]  out_boffs_o;
  logic        out_gnt_i, out_r_valid_i, out_r_opc_i;
  logic [31:0] out_r_data_i;
  logic [2:0]  occupancy_o;
  logic        resp_err_o;

  int tests = 0;
  int fails = 0;

  hci_core_req_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_wen_i(in_wen_i), .in_lrdy_i(in_lrdy_i),
    .in_add_i(in_add_i), .in_data_i(in_data_i), .in_be_i(in_be_i),
    .in_boffs_i(in_boffs_i), .in_gnt_o(in_gnt_o), .in_r_valid_o(in_r_valid_o),
    .in_r_opc_o(in_r_opc_o), .in_r_data_o(in_r_data_o),
    .out_req_o(out_req_o), .out_wen_o(out_wen_o), .out_lrdy_o(out_lrdy_o),
    .out_add_o(out_add_o), .out_data_o(out_data_o), .out_be_o(out_be_o),
    .out_boffs_o(out_boffs_o), .out_gnt_i(out_gnt_i),
    .out_r_valid_i(out_r_valid_i), .out_r_opc_i(out_r_opc_i),
    .out_r_data_i(out_r_data_i), .occupancy_o(occupancy_o),
    .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        wen;
    logic [31:0] add;
    logic        gnt;
    logic        rv;
    logic        clr;
    logic [2:0]  occ;
    logic        igt;
    logic        oreq;
    logic [31:0] oadd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic req, input logic wen, input logic [31:0] add,
                              input logic gnt, input logic rv, input logic clr,
                              input logic [2:0] occ, input logic igt, input logic oreq,
                              input logic [31:0] oadd, input logic err);
    vec_t v;
    v.req = req; v.wen = wen; v.add = add; v.gnt = gnt; v.rv = rv; v.clr = clr;
    v.occ = occ; v.igt = igt; v.oreq = oreq; v.oadd = oadd; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hC0DE0000 | a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wen, input logic [31:0] add,
                       input logic gnt, input logic rv, input logic clr);
    in_req_i = req; in_wen_i = wen; in_add_i = add; in_data_i = data_of(add);
    out_gnt_i = gnt; out_r_valid_i = rv; clear_i = clr;
  endtask

  logic [31:0] q[$];

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 0);
    in_lrdy_i = 1'b0; in_be_i = 4'hF; in_boffs_i = 1'b0;
    out_r_opc_i = 1'b0; out_r_data_i = 32'h0;

    // Vector table: inputs applied at negedge, expectations are pre-edge state
    //              req wen add    gnt rv clr occ igt oreq oadd   err
    vecs.push_back(mk(1, 0, 32'h40, 0, 0, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(1, 0, 32'h44, 0, 0, 0, 1, 1, 1, 32'h40, 0));
    vecs.push_back(mk(1, 0, 32'h48, 0, 0, 0, 2, 1, 1, 32'h40, 0));
    vecs.push_back(mk(1, 0, 32'h4C, 0, 0, 0, 3, 1, 1, 32'h40, 0));
    vecs.push_back(mk(1, 0, 32'h50, 0, 0, 0, 4, 0, 1, 32'h40, 0));
    vecs.push_back(mk(1, 0, 32'h50, 1, 0, 0, 4, 0, 1, 32'h40, 0)); // full + pop: no push
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 3, 1, 1, 32'h44, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 3, 1, 1, 32'h44, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 2, 1, 1, 32'h48, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 1, 1, 32'h4C, 0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1, 0, 32'h0,  0));
    // loads throttled at MAX_OUT, store queued behind the throttled load
    vecs.push_back(mk(1, 1, 32'h10, 1, 0, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(1, 1, 32'h14, 1, 0, 0, 1, 1, 1, 32'h10, 0));
    vecs.push_back(mk(1, 1, 32'h18, 1, 0, 0, 1, 1, 1, 32'h14, 0));
    vecs.push_back(mk(1, 0, 32'h20, 1, 0, 0, 1, 1, 0, 32'h18, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 2, 1, 0, 32'h18, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 0, 2, 1, 0, 32'h18, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 2, 1, 1, 32'h18, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 1, 1, 1, 32'h20, 0));
    // retire the two outstanding loads, then one unexpected response
    vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1, 0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1, 0, 32'h0,  1));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 1, 0, 32'h0,  1));
    // clear with entries buffered discards them and any same-cycle push
    vecs.push_back(mk(1, 0, 32'h70, 0, 0, 0, 0, 1, 0, 32'h0,  0));
    vecs.push_back(mk(1, 0, 32'h74, 0, 0, 0, 1, 1, 1, 32'h70, 0));
    vecs.push_back(mk(1, 0, 32'h78, 0, 0, 1, 2, 1, 1, 32'h70, 0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 1, 0, 32'h0,  0));

    // Reset state
    #2;
    check("rst_occ",  32'(occupancy_o), 32'd0);
    check("rst_oreq", 32'(out_req_o),   32'd0);
    check("rst_igt",  32'(in_gnt_o),    32'd1);
    check("rst_err",  32'(resp_err_o),  32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].req, vecs[i].wen, vecs[i].add, vecs[i].gnt, vecs[i].rv, vecs[i].clr);
      #1;
      $display("[TB] vec %0d req=%0b add=0x%0h gnt=%0b rv=%0b clr=%0b -> occ=%0d igt=%0b oreq=%0b oadd=0x%0h err=%0b",
               i, vecs[i].req, vecs[i].add, vecs[i].gnt, vecs[i].rv, vecs[i].clr,
               occupancy_o, in_gnt_o, out_req_o, out_add_o, resp_err_o);
      check($sformatf("v%0d_occ", i),  32'(occupancy_o),  32'(vecs[i].occ));
      check($sformatf("v%0d_igt", i),  32'(in_gnt_o),     32'(vecs[i].igt));
      check($sformatf("v%0d_oreq", i), 32'(out_req_o),    32'(vecs[i].oreq));
      check($sformatf("v%0d_err", i),  32'(resp_err_o),   32'(vecs[i].err));
      check($sformatf("v%0d_rv", i),   32'(in_r_valid_o), 32'(vecs[i].rv));
      if (vecs[i].occ != 3'd0) begin
        check($sformatf("v%0d_oadd", i),  out_add_o,  vecs[i].oadd);
        check($sformatf("v%0d_odata", i), out_data_o, data_of(vecs[i].oadd));
      end
    end

    // Combinational response / lrdy pass-through
    @(negedge clk_i);
    drive(0, 0, 32'h0, 0, 0, 0);
    out_r_data_i = 32'hDEADBEEF; out_r_opc_i = 1'b1; in_lrdy_i = 1'b1;
    #1;
    $display("[TB] passthru r_data=0x%0h r_opc=%0b lrdy=%0b", in_r_data_o, in_r_opc_o, out_lrdy_o);
    check("pt_data", in_r_data_o, 32'hDEADBEEF);
    check("pt_opc",  32'(in_r_opc_o), 32'd1);
    check("pt_lrdy", 32'(out_lrdy_o), 32'd1);
    out_r_opc_i = 1'b0; in_lrdy_i = 1'b0;

    // Steady push+pop at occupancy 2 across several pointer wraps
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      drive(1, 0, 32'h100 + 32'(4 * k), 0, 0, 0);
      q.push_back(32'h100 + 32'(4 * k));
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      drive(1, 0, 32'h108 + 32'(4 * k), 1, 0, 0);
      #1;
      $display("[TB] stream %0d push=0x%0h occ=%0d head=0x%0h", k, in_add_i, occupancy_o, out_add_o);
      check($sformatf("st%0d_occ", k),  32'(occupancy_o), 32'd2);
      check($sformatf("st%0d_head", k), out_add_o, q[0]);
      check($sformatf("st%0d_req", k),  32'(out_req_o), 32'd1);
      q.push_back(in_add_i);
      void'(q.pop_front());
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      drive(0, 0, 32'h0, 1, 0, 0);
      #1;
      $display("[TB] drain %0d head=0x%0h", k, out_add_o);
      check($sformatf("dr%0d_head", k), out_add_o, q[0]);
      void'(q.pop_front());
    end
    @(negedge clk_i);
    drive(0, 0, 32'h0, 0, 0, 0);
    #1;
    check("dr_empty", 32'(occupancy_o), 32'd0);

    // Asynchronous reset with three entries buffered
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      drive(1, 0, 32'h200 + 32'(4 * k), 0, 0, 0);
    end
    @(negedge clk_i);
    drive(0, 0, 32'h0, 0, 0, 0);
    #1;
    check("ar_pre_occ", 32'(occupancy_o), 32'd3);
    #1;
    rst_ni = 1'b0;
    #1;
    $display("[TB] async reset occ=%0d oreq=%0b igt=%0b", occupancy_o, out_req_o, in_gnt_o);
    check("ar_occ",  32'(occupancy_o), 32'd0);
    check("ar_oreq", 32'(out_req_o),   32'd0);
    check("ar_igt",  32'(in_gnt_o),    32'd1);
    @(negedge clk_i);
    drive(0, 0, 32'h0, 1, 0, 0);
    rst_ni = 1'b1;
    #1;
    check("ar_rel_igt", 32'(in_gnt_o), 32'd1);
    @(negedge clk_i);
    #1;
    check("ar_rel_oreq", 32'(out_req_o),   32'd0);
    check("ar_rel_occ",  32'(occupancy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
